ad_sample_capture: RTL
======================

// Module: ad_sample_capture
// PURPOSE
//  ADC-side responder to the ad_start strobes from the AD sampling-rate controller.
//  On each ad_start rising edge it runs one conversion on a parallel-bus 8-ch ADC:
//  CONVST pulse, wait on BUSY, then per-channel CS/RD read. Each channel word is
//  emitted as a one-cycle sample strobe to the downstream packer/FIFO.
//  Conversion errors (BUSY timeout, start-while-busy overrun) are flagged.
// PARAMETERS
//  NCH      8     channels read per conversion (1..8)
//  DW       16    ADC data bus width
//  CONV_W   4     clk cycles ad_convst is held low
//  RD_W     3     clk cycles ad_rd_n is low, and clk cycles it is high between channels
//  BUSY_TO  1023  max clk cycles spent in each BUSY wait state before timeout
// PORTS
//  clk         in   1    system clock, single domain
//  rst         in   1    synchronous reset, active-high
//  ad_en       in   1    capture enable (register-bank control)
//  ad_start    in   1    conversion request; level pulse of >=1 cycle, rising edge used
//  ad_busy     in   1    ADC BUSY, asynchronous; 2-flop synchronised internally
//  ad_db       in   DW   ADC parallel data bus
//  ad_convst   out  1    ADC convert start, active-low pulse
//  ad_cs_n     out  1    ADC chip select, active-low
//  ad_rd_n     out  1    ADC read strobe, active-low
//  smp_data    out  DW   captured channel word
//  smp_ch      out  3    channel index of smp_data, 0..NCH-1
//  smp_valid   out  1    one-cycle strobe, smp_data/smp_ch valid
//  frame_done  out  1    one-cycle strobe, coincident with smp_valid of last channel
//  err_timeout out  1    one-cycle strobe, BUSY wait timed out
//  err_overrun out  1    one-cycle strobe, ad_start edge rejected while not IDLE
// BEHAVIOUR
//  Reset: state IDLE; ad_convst=1, ad_cs_n=1, ad_rd_n=1, smp_data=0, smp_ch=0.
//    All strobes are 0, synchroniser flops are 0, and the ad_start edge-detect flop is 0.
//  Edge detect: start_re = ad_start & ~ad_start_d. Accepted only in IDLE with ad_en=1.
//    A 2-cycle-wide ad_start yields exactly one conversion.
//  start_re outside IDLE: err_overrun pulses next cycle; the request is dropped, not queued.
//  States:
//    IDLE  -> CONV on accepted start_re.
//    CONV  ad_convst=0 for CONV_W cycles -> WBH (ad_convst returns to 1).
//    WBH   wait busy_s=1 -> WBL.
//    WBL   wait busy_s=0 -> RDL with ch=0.
//    RDL   ad_cs_n=0, ad_rd_n=0 for RD_W cycles. On the last RDL cycle, register ad_db:
//          - smp_data <= ad_db, smp_ch <= ch, smp_valid=1 in the following cycle.
//          If ch==NCH-1 -> DONE, else -> RDH.
//    RDH   ad_cs_n=0, ad_rd_n=1 for RD_W cycles; ch++ -> RDL.
//    DONE  ad_cs_n=1 for 1 cycle -> IDLE.
//  ad_cs_n is held low continuously from the first RDL through the last RDL.
//  Timeout: a shared counter clears on entry to WBH and WBL.
//    If it reaches BUSY_TO in either state: err_timeout pulses, go to IDLE.
//    No samples and no frame_done for that conversion.
//  ad_en deasserted in any state: next cycle go to IDLE with all ADC outputs idle.
//    A partial frame emits no frame_done; samples already emitted stand.
//  Latency: from start_re to first smp_valid = 1 + CONV_W + WBH/WBL dwell + sync(2) + RD_W + 1.
//  Counters are sized from the parameters; ch counter wraps only via the state machine.
//  rst has priority over everything; asserting it mid-read releases cs/rd the next cycle.
// TESTING
//  T1 NCH=8, BUSY high 20 cycles after convst, ad_db=ch*0x1111
//     -> 8 smp_valid, data 0x0000..0x7777, smp_ch 0..7, frame_done with ch 7.
//  T2 ad_start held 2 cycles -> exactly one ad_convst low pulse of CONV_W=4 cycles.
//  T3 BUSY never rises -> err_timeout at cycle 1024 of WBH, no smp_valid, back to IDLE.
//  T4 second ad_start edge during RDL of ch 3 -> err_overrun pulse; frame completes all 8 ch.
//  T5 ad_en dropped during RDH of ch 5 -> cs_n/rd_n=1 next cycle, no frame_done;
//     the next start runs a full frame.
//  T6 rst asserted in WBL -> all outputs at reset values next cycle; BUSY later ignored.

Source files
------------

// File: rtl/ad_sample_capture.sv
// rtl/ad_sample_capture.sv - parallel-bus ADC conversion sequencer and per-channel sample capture
// One ad_start edge runs CONVST, BUSY handshake and a CS/RD burst over NCH channels.
module ad_sample_capture #(
  parameter int NCH     = 8,
  parameter int DW      = 16,
  parameter int CONV_W  = 4,
  parameter int RD_W    = 3,
  parameter int BUSY_TO = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ad_en,
  input  logic          ad_start,
  input  logic          ad_busy,
  input  logic [DW-1:0] ad_db,
  output logic          ad_convst,
  output logic          ad_cs_n,
  output logic          ad_rd_n,
  output logic [DW-1:0] smp_data,
  output logic [2:0]    smp_ch,
  output logic          smp_valid,
  output logic          frame_done,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int CMAX0 = (CONV_W > RD_W) ? CONV_W : RD_W;
  localparam int CMAX  = (BUSY_TO > CMAX0) ? BUSY_TO : CMAX0;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_W - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_W - 1);
  // Leaving at BUSY_TO-1 bounds the dwell in each wait state to BUSY_TO cycles.
  localparam logic [CW-1:0] TO_LAST   = CW'(BUSY_TO - 1);
  localparam logic [2:0]    CH_LAST   = 3'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_WBH, S_WBL, S_RDL, S_RDH, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    ch;
  logic          busy_m, busy_s;
  logic          start_d;
  logic          start_re;
  logic          capture;

  assign start_re = ad_start & ~start_d;
  assign capture  = (state == S_RDL) && (cnt == RD_LAST) && ad_en;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ad_en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_re) state_nx = S_CONV;
        S_CONV: if (cnt == CONV_LAST) state_nx = S_WBH;
        S_WBH: begin
          if (busy_s)                state_nx = S_WBL;
          else if (cnt == TO_LAST)   state_nx = S_IDLE;
        end
        S_WBL: begin
          if (!busy_s)               state_nx = S_RDL;
          else if (cnt == TO_LAST)   state_nx = S_IDLE;
        end
        S_RDL: if (cnt == RD_LAST) state_nx = (ch == CH_LAST) ? S_DONE : S_RDH;
        S_RDH: if (cnt == RD_LAST) state_nx = S_RDL;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ad_convst = 1'b1;
    ad_cs_n   = 1'b1;
    ad_rd_n   = 1'b1;
    case (state)
      S_CONV: ad_convst = 1'b0;
      S_RDL: begin
        ad_cs_n = 1'b0;
        ad_rd_n = 1'b0;
      end
      S_RDH: ad_cs_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      ch          <= '0;
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      start_d     <= 1'b0;
      smp_data    <= '0;
      smp_ch      <= '0;
      smp_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      busy_m  <= ad_busy;
      busy_s  <= busy_m;
      start_d <= ad_start;
      // One shared counter: it restarts on every state entry.
      if (state_nx != state || state_nx == S_IDLE) cnt <= '0;
      else                                         cnt <= cnt + 1'b1;

      if (state == S_WBL && state_nx == S_RDL)      ch <= '0;
      else if (state == S_RDH && state_nx == S_RDL) ch <= ch + 3'd1;

      smp_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= ad_en && (state == S_WBH || state == S_WBL) && (state_nx == S_IDLE);
      err_overrun <= start_re && (state != S_IDLE);
      if (capture) begin
        smp_data   <= ad_db;
        smp_ch     <= ch;
        smp_valid  <= 1'b1;
        frame_done <= (ch == CH_LAST);
      end
    end
  end

endmodule
